// File: rtl/dsp_mult_bank.sv
// Bank of clock-enabled pipelined 18x18 multipliers with optional per-bank accumulate.
// Pipeline depth selectable 1..3 (LATENCY); the acc qualifiers travel with their operand set.
module dsp_mult_bank #(
   parameter int unsigned LANES   = 5,
   parameter int unsigned LATENCY = 2,
   parameter bit          SIGNED  = 1'b0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        dsp_ce,
   input  logic                        flush,
   input  logic                        acc_en,
   input  logic                        acc_clr,
   input  logic [LANES-1:0][17:0]      dsp_a0,
   input  logic [LANES-1:0][17:0]      dsp_b0,
   output logic [LANES-1:0][36:0]      dsp_out,
   output logic                        out_valid
);

   // Full 36-bit product, widened to 37 bits by zero- or sign-extension.
   function automatic logic [36:0] mul_ext(input logic [17:0] a, input logic [17:0] b);
      logic [35:0] p;
      if (SIGNED) begin
         p = $signed(a) * $signed(b);
         return {p[35], p};
      end else begin
         p = a * b;
         return {1'b0, p};
      end
   endfunction

   logic [LANES-1:0][17:0] w_s2_a;
   logic [LANES-1:0][17:0] w_s2_b;
   logic                   w_s2_en;
   logic                   w_s2_clr;
   logic [LANES-1:0][36:0] w_prod;
   logic [LANES-1:0][36:0] w_s3_p;
   logic                   w_s3_en;
   logic                   w_s3_clr;
   logic [LANES-1:0][36:0] r_out;
   logic [1:0]             r_fill;

   // S1: operand/qualifier capture, present only in the three-stage build.
   generate
      if (LATENCY >= 3) begin : g_s1
         logic [LANES-1:0][17:0] r_s1_a;
         logic [LANES-1:0][17:0] r_s1_b;
         logic                   r_s1_en;
         logic                   r_s1_clr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s1_a   <= '0;
               r_s1_b   <= '0;
               r_s1_en  <= 1'b0;
               r_s1_clr <= 1'b0;
            end else if (flush) begin
               r_s1_a   <= '0;
               r_s1_b   <= '0;
               r_s1_en  <= 1'b0;
               r_s1_clr <= 1'b0;
            end else if (dsp_ce) begin
               r_s1_a   <= dsp_a0;
               r_s1_b   <= dsp_b0;
               r_s1_en  <= acc_en;
               r_s1_clr <= acc_clr;
            end
         end

         assign w_s2_a   = r_s1_a;
         assign w_s2_b   = r_s1_b;
         assign w_s2_en  = r_s1_en;
         assign w_s2_clr = r_s1_clr;
      end else begin : g_no_s1
         assign w_s2_a   = dsp_a0;
         assign w_s2_b   = dsp_b0;
         assign w_s2_en  = acc_en;
         assign w_s2_clr = acc_clr;
      end
   endgenerate

   always_comb begin
      w_prod = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_prod[i] = mul_ext(w_s2_a[i], w_s2_b[i]);
      end
   end

   // S2: product register; in the single-stage build the product feeds S3 directly.
   generate
      if (LATENCY >= 2) begin : g_s2
         logic [LANES-1:0][36:0] r_s2_p;
         logic                   r_s2_en;
         logic                   r_s2_clr;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_s2_p   <= '0;
               r_s2_en  <= 1'b0;
               r_s2_clr <= 1'b0;
            end else if (flush) begin
               r_s2_p   <= '0;
               r_s2_en  <= 1'b0;
               r_s2_clr <= 1'b0;
            end else if (dsp_ce) begin
               r_s2_p   <= w_prod;
               r_s2_en  <= w_s2_en;
               r_s2_clr <= w_s2_clr;
            end
         end

         assign w_s3_p   = r_s2_p;
         assign w_s3_en  = r_s2_en;
         assign w_s3_clr = r_s2_clr;
      end else begin : g_no_s2
         assign w_s3_p   = w_prod;
         assign w_s3_en  = w_s2_en;
         assign w_s3_clr = w_s2_clr;
      end
   endgenerate

   // S3: output/accumulate register; acc_clr wins over acc_en, sum wraps modulo 2^37.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= '0;
      end else if (flush) begin
         r_out <= '0;
      end else if (dsp_ce) begin
         for (int unsigned i = 0; i < LANES; i++) begin
            if (w_s3_clr) begin
               r_out[i] <= w_s3_p[i];
            end else if (w_s3_en) begin
               r_out[i] <= r_out[i] + w_s3_p[i];
            end else begin
               r_out[i] <= w_s3_p[i];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fill <= '0;
      end else if (flush) begin
         r_fill <= '0;
      end else if (dsp_ce && (r_fill != 2'(LATENCY))) begin
         r_fill <= r_fill + 2'd1;
      end
   end

   assign dsp_out   = r_out;
   assign out_valid = (r_fill == 2'(LATENCY));

endmodule

// File: tb/tb_dsp_mult_bank.sv
// Scoreboard bench for dsp_mult_bank: three builds (L2 unsigned, L3 signed, L1 unsigned)
// share one stimulus stream; operand sets queue per build and retire after LATENCY ce edges.
module tb_dsp_mult_bank;

   typedef logic [4:0][17:0] lanes_t;
   typedef logic [4:0][36:0] outs_t;
   typedef struct {
      lanes_t a;
      lanes_t b;
      logic   en;
      logic   clr;
   } op_t;

   logic   clk;
   logic   rst_n;
   logic   dsp_ce;
   logic   flush;
   logic   acc_en;
   logic   acc_clr;
   lanes_t dsp_a0;
   lanes_t dsp_b0;
   outs_t  o2_out, o3_out, o1_out;
   logic   v2, v3, v1;

   int     n_checks = 0;
   int     n_errors = 0;

   int unsigned LAT [3] = '{2, 3, 1};
   bit          SG  [3] = '{1'b0, 1'b1, 1'b0};
   op_t         sbq [3][$];
   logic [36:0] macc [3][5];
   logic        mvalid [3];

   dsp_mult_bank #(.LANES(5), .LATENCY(2), .SIGNED(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .dsp_ce(dsp_ce), .flush(flush), .acc_en(acc_en),
      .acc_clr(acc_clr), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_out(o2_out), .out_valid(v2));

   dsp_mult_bank #(.LANES(5), .LATENCY(3), .SIGNED(1'b1)) u_dut_l3s (
      .clk(clk), .rst_n(rst_n), .dsp_ce(dsp_ce), .flush(flush), .acc_en(acc_en),
      .acc_clr(acc_clr), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_out(o3_out), .out_valid(v3));

   dsp_mult_bank #(.LANES(5), .LATENCY(1), .SIGNED(1'b0)) u_dut_l1 (
      .clk(clk), .rst_n(rst_n), .dsp_ce(dsp_ce), .flush(flush), .acc_en(acc_en),
      .acc_clr(acc_clr), .dsp_a0(dsp_a0), .dsp_b0(dsp_b0), .dsp_out(o1_out), .out_valid(v1));

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string tag, input logic [36:0] got, input logic [36:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [36:0] ref_prod(input logic [17:0] a, input logic [17:0] b, input bit sg);
      logic signed [36:0] sa, sb;
      if (sg) begin
         sa = {{19{a[17]}}, a};
         sb = {{19{b[17]}}, b};
         return sa * sb;
      end
      return {19'd0, a} * {19'd0, b};
   endfunction

   function automatic logic [36:0] get_out(input int k, input int l);
      case (k)
         0:       return o2_out[l];
         1:       return o3_out[l];
         default: return o1_out[l];
      endcase
   endfunction

   function automatic logic get_valid(input int k);
      case (k)
         0:       return v2;
         1:       return v3;
         default: return v1;
      endcase
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         sbq[k].delete();
         mvalid[k] = 1'b0;
         for (int l = 0; l < 5; l++) macc[k][l] = '0;
      end
   endtask

   task automatic model_edge(input logic fl, input logic ce, input logic en, input logic clr,
                             input lanes_t a, input lanes_t b);
      op_t op, o;
      logic [36:0] p;
      op.a = a; op.b = b; op.en = en; op.clr = clr;
      if (fl) begin
         model_clear();
      end else if (ce) begin
         for (int k = 0; k < 3; k++) begin
            sbq[k].push_back(op);
            if (sbq[k].size() == int'(LAT[k])) begin
               o = sbq[k].pop_front();
               mvalid[k] = 1'b1;
               for (int l = 0; l < 5; l++) begin
                  p = ref_prod(o.a[l], o.b[l], SG[k]);
                  if (o.clr)     macc[k][l] = p;
                  else if (o.en) macc[k][l] = macc[k][l] + p;
                  else           macc[k][l] = p;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < 3; k++) begin
         for (int l = 0; l < 5; l++)
            check($sformatf("out_k%0d_l%0d", k, l), get_out(k, l), macc[k][l]);
         check($sformatf("valid_k%0d", k), {36'd0, get_valid(k)}, {36'd0, mvalid[k]});
      end
   endtask

   task automatic step(input logic ce, input logic fl, input logic en, input logic clr,
                       input lanes_t a, input lanes_t b);
      dsp_ce = ce; flush = fl; acc_en = en; acc_clr = clr; dsp_a0 = a; dsp_b0 = b;
      @(posedge clk);
      model_edge(fl, ce, en, clr, a, b);
      #1;
      compare_all();
   endtask

   initial begin
      lanes_t      va, vb;
      logic [36:0] wrap_exp, wp;
      rst_n = 1'b0; dsp_ce = 1'b0; flush = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
      dsp_a0 = '0; dsp_b0 = '0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst_n = 1'b1;

      // 1: reset release and latency
      va = '0; vb = '0; va[0] = 18'd255; vb[0] = 18'd255;
      step(1, 0, 0, 0, va, vb);
      check("t1_valid_e1", {36'd0, v2}, 37'd0);
      step(1, 0, 0, 0, va, vb);
      check("t1_out0", o2_out[0], 37'd65025);
      check("t1_valid_e2", {36'd0, v2}, 37'd1);
      check("t1_out1", o2_out[1], 37'd0);

      // 2: ce stall
      va[0] = 18'd3; vb[0] = 18'd4;
      step(1, 0, 0, 0, va, vb);
      step(1, 0, 0, 0, va, vb);
      check("t2_pre", o2_out[0], 37'd12);
      va[0] = 18'd7; vb[0] = 18'd7;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 0, va, vb);
         check("t2_hold", o2_out[0], 37'd12);
         check("t2_valid", {36'd0, v2}, 37'd1);
      end
      va[0] = 18'd5; vb[0] = 18'd6;
      step(1, 0, 0, 0, va, vb);
      check("t2_e1", o2_out[0], 37'd12);
      step(1, 0, 0, 0, va, vb);
      check("t2_e2", o2_out[0], 37'd30);

      // 3: accumulate on lane 2
      va = '0; vb = '0; va[2] = 18'd200; vb[2] = 18'd100;
      for (int i = 0; i < 16; i++) step(1, 0, 1, (i == 0), va, vb);
      va = '0; vb = '0;
      step(1, 0, 1, 0, va, vb);
      step(1, 0, 1, 0, va, vb);
      check("t3_acc", o2_out[2], 37'd320000);
      check("t3_acc_l3", o3_out[2], 37'd320000);
      va[2] = 18'd1; vb[2] = 18'd1;
      step(1, 0, 1, 1, va, vb);
      va = '0; vb = '0;
      step(1, 0, 1, 0, va, vb);
      step(1, 0, 1, 0, va, vb);
      check("t3_clr", o2_out[2], 37'd1);

      // 4: wrap and signed
      va = '0; vb = '0; va[0] = 18'd131071; vb[0] = 18'd131071;
      wp = 37'd131071 * 37'd131071;
      wrap_exp = '0;
      for (int i = 0; i < 12; i++) begin
         step(1, 0, 1, (i == 0), va, vb);
         wrap_exp = wrap_exp + wp;
      end
      va = '0; vb = '0;
      step(1, 0, 1, 0, va, vb);
      step(1, 0, 1, 0, va, vb);
      check("t4_wrap", o2_out[0], wrap_exp);
      check("t4_wrap_valid", {36'd0, v2}, 37'd1);
      va[0] = 18'h3FFFF; vb[0] = 18'd5;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, va, vb);
      check("t4_signed", o3_out[0], 37'h1FFFFFFFFB);
      check("t4_unsigned", o2_out[0], 37'd1310715);

      // 5: flush with products in flight, then async reset pulse
      va[0] = 18'd9; vb[0] = 18'd9;
      step(1, 0, 0, 0, va, vb);
      va[0] = 18'd10; vb[0] = 18'd10;
      step(1, 0, 0, 0, va, vb);
      step(1, 1, 1, 1, va, vb);
      check("t5_flush_out", o2_out[0], 37'd0);
      check("t5_flush_valid", {36'd0, v2}, 37'd0);
      va[0] = 18'd2; vb[0] = 18'd3;
      step(1, 0, 0, 0, va, vb);
      check("t5_refill_e1", {36'd0, v2}, 37'd0);
      step(1, 0, 0, 0, va, vb);
      check("t5_refill_e2", o2_out[0], 37'd6);
      check("t5_refill_v", {36'd0, v2}, 37'd1);
      #4 rst_n = 1'b0;
      #1;
      model_clear();
      compare_all();
      check("t5_rst_out", o2_out[0], 37'd0);
      #2 rst_n = 1'b1;

      // 6: randomized operand sets with ce gaps and occasional accumulate
      for (int n = 0; n < 1000; n++) begin
         int gaps;
         gaps = $urandom_range(0, 2);
         for (int g = 0; g < gaps; g++) begin
            for (int l = 0; l < 5; l++) begin va[l] = 18'($urandom); vb[l] = 18'($urandom); end
            step(0, 0, 1'($urandom), 1'($urandom), va, vb);
         end
         for (int l = 0; l < 5; l++) begin va[l] = 18'($urandom); vb[l] = 18'($urandom); end
         step(1, 0, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), va, vb);
      end
      va = '0; vb = '0;
      repeat (3) step(1, 0, 0, 0, va, vb);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
